// File: rtl/fruit_spawner.sv
// fruit_spawner: launch controller for one object slot, sitting directly
// upstream of the per-object motion stage. It waits a pseudo-random number
// of moveclk ticks, loads launch position/velocity/direction while holding
// the motion stage in reset, then releases it and waits for the object to
// be sliced (hit) or to leave the screen (miss) before scheduling the next
// launch.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   en_i         spawning enabled; low forces IDLE
//   moveclk_i    slow motion tick, edge-detected on clk_i
//   oob_i        out-of-bound flag from the motion stage
//   sliced_i     object hit by the blade (level)
//   obj_rstn_o   active-low reset to the motion stage
//   moveen_o     motion enable to the motion stage
//   initposx_o   launch x (64..511)
//   initposy_o   launch y (SPAWN_Y)
//   initvx_o     launch x speed (1..16)
//   initvy_o     launch y speed (12..19)
//   initdx_o     1 = +x
//   initdy_o     1 = +y (down); always launches upward
//   active_o     object in flight
//   hit_pulse_o  one-cycle pulse, retired by slice
//   miss_pulse_o one-cycle pulse, retired by out-of-bound
//   spawn_count_o launches since reset, wraps
//
// state | meaning
// IDLE  | spawning disabled, motion stage held in reset
// DELAY | counting moveclk ticks until the next launch
// LOAD  | two clocks of motion-stage reset with launch values stable
// FLY   | object in flight, watching sliced/oob to retire it

module fruit_spawner #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          MIN_DELAY  = 8,
  parameter logic [8:0]  SPAWN_Y    = 9'd440,
  parameter logic [9:0]  SCREEN_MID = 10'd320
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       moveclk_i,
  input  logic       oob_i,
  input  logic       sliced_i,
  output logic       obj_rstn_o,
  output logic       moveen_o,
  output logic [9:0] initposx_o,
  output logic [8:0] initposy_o,
  output logic [9:0] initvx_o,
  output logic [8:0] initvy_o,
  output logic       initdx_o,
  output logic       initdy_o,
  output logic       active_o,
  output logic       hit_pulse_o,
  output logic       miss_pulse_o,
  output logic [7:0] spawn_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_LOAD  = 2'd2,
    S_FLY   = 2'd3
  } state_e;

  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  MIN_DLY  = 8'(MIN_DELAY);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  mc_q;
  logic        oob_q;
  logic        armed_q, armed_d;
  logic [7:0]  delay_q, delay_d;
  logic        load_q, load_d;

  logic        obj_rstn_q, moveen_q, active_q;
  logic        hit_q, miss_q;
  logic [7:0]  count_q;
  logic [9:0]  posx_q, vx_q;
  logic [8:0]  posy_q, vy_q;
  logic        dx_q, dy_q;

  logic        tick;
  logic        launch;
  logic        hit_d, miss_d;
  logic [8:0]  r_pos;
  logic [9:0]  posx_calc, vx_calc;
  logic [8:0]  vy_calc;
  logic        dx_calc;
  logic [7:0]  reload;

  // Galois form of x^16+x^14+x^13+x^11, shifting right.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // mc_q[0] is the newest sample; 01 marks a rising moveclk.
  assign tick = (mc_q == 2'b01);

  // Values above 447 fold down by 256 so x stays within 64..511.
  assign r_pos     = lfsr_q[8:0];
  assign posx_calc = 10'd64 + ((r_pos > 9'd447) ? ({1'b0, r_pos} - 10'd256) : {1'b0, r_pos});
  assign vx_calc   = 10'd1 + {6'd0, lfsr_q[12:9]};
  assign vy_calc   = 9'd12 + {6'd0, lfsr_q[15:13]};
  assign dx_calc   = (posx_calc < SCREEN_MID);
  assign reload    = MIN_DLY + {4'd0, lfsr_q[3:0]};

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    load_d  = load_q;
    armed_d = armed_q;
    launch  = 1'b0;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (!en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DELAY;
          delay_d = reload;
        end
        S_DELAY: begin
          if (tick) begin
            if (delay_q == 8'd0) begin
              state_d = S_LOAD;
              load_d  = 1'b0;
              // Latched on entry so the values are stable for both LOAD clocks.
              launch  = 1'b1;
            end else begin
              delay_d = delay_q - 8'd1;
            end
          end
        end
        S_LOAD: begin
          if (load_q) begin
            state_d = S_FLY;
            armed_d = 1'b0;
          end else begin
            load_d = 1'b1;
          end
        end
        S_FLY: begin
          if (sliced_i) begin
            hit_d = 1'b1;
          end else if (armed_q && !oob_q && oob_i) begin
            miss_d = 1'b1;
          end
          if (hit_d || miss_d) begin
            state_d = S_DELAY;
            delay_d = reload;
          end else if (!oob_i) begin
            armed_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      mc_q       <= 2'b00;
      oob_q      <= 1'b0;
      armed_q    <= 1'b0;
      delay_q    <= 8'd0;
      load_q     <= 1'b0;
      obj_rstn_q <= 1'b0;
      moveen_q   <= 1'b0;
      active_q   <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      count_q    <= 8'd0;
      posx_q     <= 10'd0;
      posy_q     <= 9'd0;
      vx_q       <= 10'd0;
      vy_q       <= 9'd0;
      dx_q       <= 1'b0;
      dy_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      mc_q       <= {mc_q[0], moveclk_i};
      oob_q      <= oob_i;
      armed_q    <= armed_d;
      delay_q    <= delay_d;
      load_q     <= load_d;
      obj_rstn_q <= (state_d == S_FLY);
      moveen_q   <= (state_d == S_FLY);
      active_q   <= (state_d == S_FLY);
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      if ((state_d == S_FLY) && (state_q != S_FLY)) begin
        count_q <= count_q + 8'd1;
      end
      if (launch) begin
        posx_q <= posx_calc;
        posy_q <= SPAWN_Y;
        vx_q   <= vx_calc;
        vy_q   <= vy_calc;
        dx_q   <= dx_calc;
        dy_q   <= 1'b0;
      end
    end
  end

  assign obj_rstn_o    = obj_rstn_q;
  assign moveen_o      = moveen_q;
  assign active_o      = active_q;
  assign hit_pulse_o   = hit_q;
  assign miss_pulse_o  = miss_q;
  assign spawn_count_o = count_q;
  assign initposx_o    = posx_q;
  assign initposy_o    = posy_q;
  assign initvx_o      = vx_q;
  assign initvy_o      = vy_q;
  assign initdx_o      = dx_q;
  assign initdy_o      = dy_q;

endmodule
